// File: rtl/satd.sv
// satd: three-stage pipelined 8-pixel SATD.
//   stage 1: per-pixel signed differences
//   stage 2: 8-point Hadamard transform (Sylvester order)
//   stage 3: sum of |coefficients|, rounded divide by 16
// One row in and one cost out per clock.
// Latency is three edges from sampling a row to that row's cost on out_diff.
module satd (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] ORG,
  input  logic [63:0] CUR,
  output logic [8:0]  out_diff
);

  // Stage-1 differences, range -255..255.
  logic signed [8:0]  r_d   [8];
  // Butterfly levels A/B/C. Each level grows one bit, so nothing can overflow.
  logic signed [9:0]  w_a   [8];
  logic signed [10:0] w_b   [8];
  logic signed [11:0] w_c   [8];
  // Stage-2 Hadamard coefficients, range +/-2040.
  logic signed [11:0] r_h   [8];
  // Magnitudes and their sum (max 5770).
  logic [10:0]        w_abs [8];
  logic [13:0]        w_sum;

  genvar gi;

  // Stage 1: register ORG_i - CUR_i as 9-bit two's complement.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (rst) r_d[i] <= '0;
      else     r_d[i] <= {1'b0, ORG[8*i +: 8]} - {1'b0, CUR[8*i +: 8]};
    end
  end

  // Level A butterflies, stride 4 (operands sign-extended by one bit).
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lvl_a
      assign w_a[gi]     = {r_d[gi][8], r_d[gi]} + {r_d[gi+4][8], r_d[gi+4]};
      assign w_a[gi + 4] = {r_d[gi][8], r_d[gi]} - {r_d[gi+4][8], r_d[gi+4]};
    end
  endgenerate

  // Level B butterflies, stride 2, inside each half of four.
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lvl_b
      localparam int LO = (gi / 2) * 4 + (gi % 2);
      assign w_b[LO]     = {w_a[LO][9], w_a[LO]} + {w_a[LO+2][9], w_a[LO+2]};
      assign w_b[LO + 2] = {w_a[LO][9], w_a[LO]} - {w_a[LO+2][9], w_a[LO+2]};
    end
  endgenerate

  // Level C butterflies, stride 1, on adjacent pairs.
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lvl_c
      assign w_c[2*gi]     = {w_b[2*gi][10], w_b[2*gi]} + {w_b[2*gi+1][10], w_b[2*gi+1]};
      assign w_c[2*gi + 1] = {w_b[2*gi][10], w_b[2*gi]} - {w_b[2*gi+1][10], w_b[2*gi+1]};
    end
  endgenerate

  // Stage 2: register the transform coefficients.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (rst) r_h[i] <= '0;
      else     r_h[i] <= w_c[i];
    end
  end

  // Absolute values. |h| <= 2040 fits in 11 bits, and -(-2040) does not wrap in 12 bits.
  generate
    for (gi = 0; gi < 8; gi++) begin : g_abs
      assign w_abs[gi] = r_h[gi][11] ? 11'(-r_h[gi]) : r_h[gi][10:0];
    end
  endgenerate

  // Adder tree over the eight magnitudes.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < 8; i++) begin
      w_sum = w_sum + {3'b000, w_abs[i]};
    end
  end

  // Stage 3: round-half-up divide by 16. The result is at most 361, so 9 bits suffice.
  always_ff @(posedge clk) begin
    if (rst) out_diff <= '0;
    else     out_diff <= 9'((w_sum + 14'd8) >> 4);
  end

endmodule

// File: tb/tb_satd.sv
// tb_satd: table vectors, reset sequences and random streaming for satd.
module tb_satd;

  logic        clk;
  logic        rst;
  logic [63:0] ORG;
  logic [63:0] CUR;
  logic [8:0]  out_diff;

  int total = 0;
  int bad   = 0;

  satd dut (
    .clk      (clk),
    .rst      (rst),
    .ORG      (ORG),
    .CUR      (CUR),
    .out_diff (out_diff)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] org;
    logic [63:0] cur;
    int          exp;
  } vec_t;

  // Reference model built directly from the transform definition.
  // H[k][i] = (-1)^popcount(i & k); cost = (sum_k |sum_i H[k][i]*d[i]| + 8) / 16.
  function automatic int model(input logic [63:0] o, input logic [63:0] c);
    int d [8];
    int s;
    int h;
    logic [7:0] po;
    logic [7:0] pc;
    s = 0;
    for (int i = 0; i < 8; i++) begin
      po   = o[8*i +: 8];
      pc   = c[8*i +: 8];
      d[i] = int'(po) - int'(pc);
    end
    for (int k = 0; k < 8; k++) begin
      h = 0;
      for (int i = 0; i < 8; i++) begin
        if ($countones(i & k) % 2 == 1) h = h - d[i];
        else                            h = h + d[i];
      end
      s = s + ((h < 0) ? -h : h);
    end
    return (s + 8) / 16;
  endfunction

  // Advance one clock edge. Outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int idx, input int exp);
    total++;
    if (out_diff !== 9'(exp)) begin
      bad++;
      $display("FAIL %s[%0d]: out_diff=%0d expected=%0d", name, idx, out_diff, exp);
    end else begin
      $display("ok   %s[%0d]: out_diff=%0d", name, idx, out_diff);
    end
  endtask

  vec_t        tbl [10];
  logic [63:0] ro  [300];
  logic [63:0] rc  [300];
  logic [63:0] v_org [3];
  logic [63:0] v_cur [3];
  int          v_exp [3];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Hand-computed expectations for the table vectors.
    tbl[0] = '{64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 0};
    tbl[1] = '{64'hFFFFFFFFFFFFFFFF, 64'h3333333333333333, 102};
    tbl[2] = '{64'h0000000000000000, 64'hFFFFFFFFFFFFFFFF, 128};
    tbl[3] = '{64'h00000000000000FF, 64'h0000000000000000, 128};
    tbl[4] = '{64'h0000000000000001, 64'h0000000000000000, 1};
    tbl[5] = '{64'h0000000000000002, 64'h0000000000000000, 1};   // s=16 -> 24>>4
    tbl[6] = '{64'h0000000000000003, 64'h0000000000000000, 2};   // s=24 -> 32>>4
    tbl[7] = '{64'hFF00FF00FF00FF00, 64'h0000000000000000, 128}; // DC and k=1 at 1020 each
    tbl[8] = '{64'hFFFFFFFFFFFFFFFF, 64'h0000000000000000, 128};
    tbl[9] = '{64'h0000000000000000, 64'h0000000000000000, 0};

    // Reset hold: two cycles of reset with a nonzero row on the inputs.
    rst = 1'b1;
    ORG = 64'hFFFFFFFFFFFFFFFF;
    CUR = 64'h0;
    tick(); check("reset_hold", 0, 0);
    tick(); check("reset_hold", 1, 0);
    rst = 1'b0;
    tick(); check("reset_release", 0, 0);
    tick(); check("reset_release", 1, 0);
    tick(); check("reset_release", 2, 128);

    // Table vectors, streamed back to back.
    for (int c = 0; c < 12; c++) begin
      if (c < 10) begin
        ORG = tbl[c].org;
        CUR = tbl[c].cur;
      end else begin
        ORG = 64'h0;
        CUR = 64'h0;
      end
      tick();
      if (c >= 2) check("table", c - 2, tbl[c-2].exp);
    end

    // Streaming with a one-cycle reset mid-stream.
    v_org[0] = 64'hFFFFFFFFFFFFFFFF; v_cur[0] = 64'h3333333333333333; v_exp[0] = 102;
    v_org[1] = 64'h0000000000000000; v_cur[1] = 64'hFFFFFFFFFFFFFFFF; v_exp[1] = 128;
    v_org[2] = 64'h00000000000000FF; v_cur[2] = 64'h0000000000000000; v_exp[2] = 128;
    // Flush leftover table rows so the output starts from a known zero cost.
    ORG = 64'h0; CUR = 64'h0;
    tick(); tick(); tick();
    ORG = v_org[0]; CUR = v_cur[0]; tick();
    ORG = v_org[1]; CUR = v_cur[1]; tick();
    // Reset coincides with v2: v0 would have appeared now but is discarded.
    rst = 1'b1; ORG = v_org[2]; CUR = v_cur[2]; tick();
    check("midreset_during", 0, 0);
    rst = 1'b0;
    ORG = v_org[0]; CUR = v_cur[0]; tick(); check("midreset_after", 0, 0);
    ORG = v_org[1]; CUR = v_cur[1]; tick(); check("midreset_after", 1, 0);
    ORG = v_org[2]; CUR = v_cur[2]; tick(); check("midreset_stream", 0, v_exp[0]);
    ORG = 64'h0;    CUR = 64'h0;    tick(); check("midreset_stream", 1, v_exp[1]);
    tick(); check("midreset_stream", 2, v_exp[2]);

    // Random streaming against the reference model.
    // Pixels are biased toward 0 and 255 so the extreme coefficients get exercised.
    for (int n = 0; n < 300; n++) begin
      for (int p = 0; p < 8; p++) begin
        case ($urandom_range(0, 3))
          0:       begin ro[n][8*p +: 8] = 8'hFF; rc[n][8*p +: 8] = 8'h00; end
          1:       begin ro[n][8*p +: 8] = 8'h00; rc[n][8*p +: 8] = 8'hFF; end
          default: begin ro[n][8*p +: 8] = 8'($urandom); rc[n][8*p +: 8] = 8'($urandom); end
        endcase
      end
    end
    for (int c = 0; c < 302; c++) begin
      if (c < 300) begin
        ORG = ro[c];
        CUR = rc[c];
      end else begin
        ORG = 64'h0;
        CUR = 64'h0;
      end
      tick();
      if (c >= 2) check("random", c - 2, model(ro[c-2], rc[c-2]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
